regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port register file with pending-write scoreboard, for the CPU decode/writeback boundary. Write and read are synchronous on the rising edge of one clock. Read data is registered, with optional same-cycle write-to-read bypass. A per-register busy bit tracks destinations claimed by in-flight instructions so decode can detect RAW hazards. Register 0 is optionally hardwired to zero.

## Interface
- XLEN, 32: data width in bits.
- NREG, 32: number of registers, power of two, ≥ 2.
- AW, $clog2(NREG): address width (derived).
- NRD, 2: number of read ports, 1–4.
- ZERO_REG, 1: 1 = register 0 reads 0, ignores writes and claims, never busy.
- BYPASS, 1: 1 = same-cycle write data is forwarded to a matching read.

- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_en  in  NRD  per-port read enable; when low, that port's outputs hold.
- rr_addr  in  NRD*AW  packed read addresses, port p at [p*AW +: AW].
- rd_data  out  NRD*XLEN  packed registered read data.
- rd_busy  out  NRD  registered busy bit of the addressed register.
- we  in  1  write enable (writeback).
- wr  in  AW  write address.
- wd  in  XLEN  write data.
- claim_en  in  1  mark register claim_addr pending (decode issue).
- claim_addr  in  AW  register to mark pending.
- busy_vec  out  NREG  current scoreboard state, combinational from the busy flops.

## Operation
- Storage: NREG × XLEN flops, plus NREG busy flops.
- Write: on a rising edge with we=1, `reg[wr] <= wd` and `busy[wr] <= 0`. Exception: if ZERO_REG=1 and wr=0, nothing changes.
- Claim: on a rising edge with claim_en=1, `busy[claim_addr] <= 1`. Ignored if ZERO_REG=1 and claim_addr=0.
- Claim and write to the same address in one cycle: the data is written and the busy bit ends at 1 (claim wins; a newer producer is pending).
- Claim and write to different addresses: both take effect.
- Read, per port p: on a rising edge with rd_en[p]=1:
  - rd_data[p] <= value of reg[rr_addr[p]], with rd_busy[p] <= busy[rr_addr[p]].
  - If BYPASS=1, we=1 and wr==rr_addr[p] (and not the zero register): rd_data[p] <= wd. rd_busy[p] <= 0, or 1 if a claim to the same address is also present this cycle.
  - If BYPASS=0: the read returns the pre-write value and the pre-update busy bit.
  - If ZERO_REG=1 and rr_addr[p]=0: rd_data[p] <= 0 and rd_busy[p] <= 0, regardless of any other condition.
- Read ports are independent. Any number of ports may address the same register.
- rd_en[p]=0: rd_data[p] and rd_busy[p] hold their previous values.
- Address range: all AW-bit addresses are valid, since NREG = 2^AW. There is no wrap or out-of-range case.

## Timing
- Reset (rst_n low, asynchronous, no clock required):
  - all registers = 0;
  - all busy bits = 0;
  - rd_data = 0, rd_busy = 0, busy_vec = 0.
- Reset deassertion is taken synchronously by the surrounding logic. The first rising edge with rst_n high performs normal operation.
- Reset asserted mid-operation aborts any same-edge write or claim. State is zero immediately on assertion.
- Read latency: 1 cycle. Addresses presented before edge N give data valid after edge N.
- Write-to-read:
  - with BYPASS=1, a read on the same edge as the write sees the new value;
  - with BYPASS=0, it sees the new value from the following edge.
- Claim-to-busy: busy_vec reflects a claim after the same edge. rd_busy reflects it on the next read edge, or the same edge under the bypass rule above.
- No combinational path from any input to rd_data or rd_busy. busy_vec depends only on flops.

## Test plan
- Reset: load r5=4, r9=7, claim r3, then pulse rst_n low mid-cycle → busy_vec=0 and rd_data=0 immediately; next reads of r5 and r9 return 0.
- Write/read: write r5=0x0000_0004, then r9=0xDEAD_BEEF; read port0=r5, port1=r9 one cycle later → rd_data = 0x4 and 0xDEADBEEF, rd_busy = 0,0.
- Bypass: same edge, we=1 wr=7 wd=0x1234 and port0 reads r7 (old value 0) → rd_data[0]=0x1234 with BYPASS=1; rd_data[0]=0 with BYPASS=0, then 0x1234 on the next read.
- Zero register: write r0=0xFFFF_FFFF and claim r0, then read r0 on all ports → rd_data=0, rd_busy=0, busy_vec[0]=0. With ZERO_REG=0, the read returns 0xFFFFFFFF.
- Scoreboard:
  - claim r12 → busy_vec[12]=1;
  - read r12 → rd_busy=1;
  - write r12=0x55 → busy_vec[12]=0;
  - simultaneous claim and write of r12 → data 0x55 stored, busy_vec[12]=1.
- Hold and multiport: NRD=4, all ports read r9, then drop rd_en[2] and change rr_addr[2] → ports 0, 1, 3 update; port 2 holds 0xDEADBEEF.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read-port register file with pending-write scoreboard for the decode/writeback boundary.
// Reads are registered; optional same-edge write bypass and hardwired-zero register 0.
module regfile_mp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned AW       = $clog2(NREG),
  parameter int unsigned NRD      = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rr_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                we,
  input  logic [AW-1:0]       wr,
  input  logic [XLEN-1:0]     wd,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_addr,
  output logic [NREG-1:0]     busy_vec
);

  logic [XLEN-1:0] regs_q  [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [XLEN-1:0] rdata_q [NRD];
  logic [XLEN-1:0] rdata_d [NRD];
  logic [NRD-1:0]  rbusy_q, rbusy_d;
  logic [AW-1:0]   raddr   [NRD];
  logic            wr_ok, claim_ok;

  assign wr_ok    = we       && !(ZERO_REG && (wr == '0));
  assign claim_ok = claim_en && !(ZERO_REG && (claim_addr == '0));

  always_comb begin
    for (int unsigned p = 0; p < NRD; p++) begin
      raddr[p] = rr_addr[p*AW +: AW];
    end
  end

  // Claim is applied after the write so a same-address claim leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[wr] = 1'b0;
    end
    if (claim_ok) begin
      busy_d[claim_addr] = 1'b1;
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NRD; p++) begin
      rdata_d[p] = rdata_q[p];
      rbusy_d[p] = rbusy_q[p];
      if (rd_en[p]) begin
        if (ZERO_REG && (raddr[p] == '0)) begin
          rdata_d[p] = '0;
          rbusy_d[p] = 1'b0;
        end else if (BYPASS && wr_ok && (wr == raddr[p])) begin
          rdata_d[p] = wd;
          rbusy_d[p] = claim_ok && (claim_addr == raddr[p]);
        end else begin
          rdata_d[p] = regs_q[raddr[p]];
          rbusy_d[p] = busy_q[raddr[p]];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[wr] <= wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      rbusy_q <= '0;
      for (int unsigned p = 0; p < NRD; p++) begin
        rdata_q[p] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      rbusy_q <= rbusy_d;
      for (int unsigned p = 0; p < NRD; p++) begin
        rdata_q[p] <= rdata_d[p];
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NRD; p++) begin
      rd_data[p*XLEN +: XLEN] = rdata_q[p];
    end
  end

  assign rd_busy  = rbusy_q;
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp: two configurations driven in parallel
// (bypass + zero register, and neither) checked each cycle against a rule-level model.
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rr_addr;
  logic                we;
  logic [AW-1:0]       wr;
  logic [XLEN-1:0]     wd;
  logic                claim_en;
  logic [AW-1:0]       claim_addr;

  logic [NRD*XLEN-1:0] a_data, b_data;
  logic [NRD-1:0]      a_busy, b_busy;
  logic [NREG-1:0]     a_vec,  b_vec;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rr_addr(rr_addr), .rd_data(a_data),
    .rd_busy(a_busy), .we(we), .wr(wr), .wd(wd), .claim_en(claim_en),
    .claim_addr(claim_addr), .busy_vec(a_vec)
  );

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rr_addr(rr_addr), .rd_data(b_data),
    .rd_busy(b_busy), .we(we), .wr(wr), .wd(wd), .claim_en(claim_en),
    .claim_addr(claim_addr), .busy_vec(b_vec)
  );

  // Behavioural model: index 0 = zero-reg + bypass, index 1 = plain.
  logic [XLEN-1:0] mreg  [2][NREG];
  bit              mbusy [2][NREG];
  logic [XLEN-1:0] md    [2][NRD];
  bit              mb    [2][NRD];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        for (int r = 0; r < NREG; r++) begin mreg[i][r] = '0; mbusy[i][r] = 0; end
        for (int p = 0; p < NRD; p++) begin md[i][p] = '0; mb[i][p] = 0; end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit zr, byp;
        int a;
        zr  = (i == 0);
        byp = (i == 0);
        for (int p = 0; p < NRD; p++) begin
          if (rd_en[p]) begin
            a = int'(rr_addr[p*AW +: AW]);
            if (zr && a == 0) begin
              md[i][p] = '0; mb[i][p] = 0;
            end else if (byp && we && int'(wr) == a) begin
              md[i][p] = wd; mb[i][p] = claim_en && int'(claim_addr) == a;
            end else begin
              md[i][p] = mreg[i][a]; mb[i][p] = mbusy[i][a];
            end
          end
        end
        if (we && !(zr && wr == 0)) begin
          mreg[i][wr] = wd; mbusy[i][wr] = 0;
        end
        if (claim_en && !(zr && claim_addr == 0)) mbusy[i][claim_addr] = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      logic [NRD*XLEN-1:0] ed [2];
      logic [NRD-1:0]      eb [2];
      logic [NREG-1:0]     ev [2];
      for (int i = 0; i < 2; i++) begin
        for (int p = 0; p < NRD; p++) begin
          ed[i][p*XLEN +: XLEN] = md[i][p];
          eb[i][p] = mb[i][p];
        end
        for (int r = 0; r < NREG; r++) ev[i][r] = mbusy[i][r];
      end
      chk("A.rd_data", a_data, ed[0]);
      chk("A.rd_busy", a_busy, eb[0]);
      chk("A.busy_vec", a_vec, ev[0]);
      chk("B.rd_data", b_data, ed[1]);
      chk("B.rd_busy", b_busy, eb[1]);
      chk("B.busy_vec", b_vec, ev[1]);
    end
  end

  task automatic idle();
    we = 0; claim_en = 0; rd_en = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int p, input logic [AW-1:0] a);
    rr_addr[p*AW +: AW] = a;
  endtask

  function automatic logic [AW-1:0] raddr();
    return ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NREG-1));
  endfunction

  initial begin
    idle();
    rr_addr = '0; wr = '0; wd = '0; claim_addr = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #12 rst_n = 1'b1;
    cmp_on = 1'b1;
    chk("reset_rd_data", a_data, '0);
    chk("reset_busy_vec", a_vec, '0);

    // Write then read r5 / r9
    we = 1; wr = 5; wd = 32'h0000_0004; cycle();
    wr = 9; wd = 32'hDEAD_BEEF; cycle();
    idle(); rd_en = 4'b0011; set_addr(0, 5); set_addr(1, 9); cycle();
    chk("rd_r5", a_data[31:0], 128'h4);
    chk("rd_r9", a_data[63:32], 128'hDEADBEEF);
    chk("rd_busy_r5_r9", a_busy[1:0], 128'h0);

    // Same-edge write/read of r7
    idle(); we = 1; wr = 7; wd = 32'h1234; rd_en = 4'b0001; set_addr(0, 7); cycle();
    chk("bypass_on", a_data[31:0], 128'h1234);
    chk("bypass_off_old", b_data[31:0], 128'h0);
    idle(); rd_en = 4'b0001; cycle();
    chk("bypass_off_next", b_data[31:0], 128'h1234);

    // Zero register: write and claim r0, read on all ports
    idle(); we = 1; wr = 0; wd = 32'hFFFF_FFFF; claim_en = 1; claim_addr = 0;
    rd_en = 4'b1111; for (int p = 0; p < NRD; p++) set_addr(p, 0);
    cycle();
    chk("zero_rd_data", a_data, '0);
    chk("zero_rd_busy", a_busy, '0);
    chk("zero_busy_vec0", a_vec[0], 128'h0);
    idle(); rd_en = 4'b1111; cycle();
    chk("nozero_rd_data", b_data[31:0], 128'hFFFFFFFF);
    chk("nozero_rd_busy", b_busy[0], 128'h1);

    // Scoreboard on r12
    idle(); claim_en = 1; claim_addr = 12; cycle();
    chk("claim_busy_vec", a_vec[12], 128'h1);
    idle(); rd_en = 4'b0001; set_addr(0, 12); cycle();
    chk("claim_rd_busy", a_busy[0], 128'h1);
    idle(); we = 1; wr = 12; wd = 32'h55; cycle();
    chk("write_clears_busy", a_vec[12], 128'h0);
    claim_en = 1; claim_addr = 12; cycle();
    chk("claim_wins", a_vec[12], 128'h1);
    idle(); rd_en = 4'b0001; cycle();
    chk("claim_write_data", a_data[31:0], 128'h55);
    chk("claim_write_busy", a_busy[0], 128'h1);

    // Hold and multiport
    idle(); rd_en = 4'b1111; for (int p = 0; p < NRD; p++) set_addr(p, 9); cycle();
    chk("multiport_r9", a_data, {4{32'hDEADBEEF}});
    rd_en = 4'b1011; for (int p = 0; p < NRD; p++) set_addr(p, 5); cycle();
    chk("hold_port2", a_data, 128'h00000004_DEADBEEF_00000004_00000004);

    // Asynchronous reset mid-cycle
    idle(); claim_en = 1; claim_addr = 3; cycle();
    idle();
    #1 rst_n = 1'b0;
    #1;
    chk("async_busy_vec", a_vec, '0);
    chk("async_rd_data", a_data, '0);
    #1 rst_n = 1'b1;
    rd_en = 4'b0011; set_addr(0, 5); set_addr(1, 9); cycle();
    chk("post_reset_r5_r9", a_data[63:0], 128'h0);
    chk("post_reset_b", b_data[63:0], 128'h0);

    // Randomised phase
    for (int n = 0; n < 3000; n++) begin
      rd_en      = NRD'($urandom);
      for (int p = 0; p < NRD; p++) set_addr(p, raddr());
      we         = ($urandom_range(0, 2) != 0);
      wr         = raddr();
      wd         = $urandom;
      claim_en   = ($urandom_range(0, 2) == 0);
      claim_addr = raddr();
      if (n % 700 == 699) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      cycle();
    end

    idle();
    cycle();
    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
